// File: rtl/zmod_link_align.sv
// zmod_link_align
// Receive-side word-alignment controller for the zmod 4-lane LVDS link
// (rxdivclk domain). It hunts for the rotation of SYNC_PATTERN on the raw
// sync-lane byte, verifies that rotation over LOCK_COUNT consecutive valid
// frames, then publishes it as the datapath shift and flags lock. While
// locked it drops back to hunting after LOSS_COUNT consecutive mismatches,
// and it keeps saturating error and relock statistics.
//
// Ports:
//   clk          rx divided clock
//   rst_n        asynchronous active-low reset
//   en           alignment enable, 0 forces IDLE
//   sync_valid   sync_byte is valid this cycle
//   sync_byte    raw deserialised sync-lane byte
//   clear_stats  synchronous clear of err_cnt / relock_cnt
//   shift        rotation for the datapath shifter
//   aligned      link word-aligned
//   state        IDLE=0, HUNT=1, VERIFY=2, LOCKED=3
//   err_cnt      saturating count of mismatches seen while LOCKED
//   relock_cnt   saturating count of LOCKED->HUNT transitions
module zmod_link_align #(
  parameter logic [7:0]  SYNC_PATTERN = 8'b0000_0001,
  parameter int unsigned LOCK_COUNT   = 64,
  parameter int unsigned LOSS_COUNT   = 4,
  parameter int unsigned ERR_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_valid,
  input  logic [7:0]       sync_byte,
  input  logic             clear_stats,
  output logic [2:0]       shift,
  output logic             aligned,
  output logic [1:0]       state,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       relock_cnt
);

  localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MISS_W = $clog2(LOSS_COUNT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } state_t;

  function automatic logic [7:0] rotl(input logic [7:0] v, input logic [2:0] k);
    logic [15:0] d;
    d = {v, v} << k;
    return d[15:8];
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc_relock(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        shift_q, shift_d;
  logic              aligned_q, aligned_d;
  logic [2:0]        cand_q, cand_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [7:0]        relock_q, relock_d;

  logic              hunt_hit;
  logic [2:0]        hunt_k;
  logic              cand_match;
  logic              shift_match;

  // Scan downwards so the lowest matching rotation wins; this also makes
  // degenerate all-zero / all-one patterns resolve to k=0.
  always_comb begin
    hunt_hit = 1'b0;
    hunt_k   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (sync_byte == rotl(SYNC_PATTERN, 3'(k))) begin
        hunt_hit = 1'b1;
        hunt_k   = 3'(k);
      end
    end
  end

  assign cand_match  = (sync_byte == rotl(SYNC_PATTERN, cand_q));
  assign shift_match = (sync_byte == rotl(SYNC_PATTERN, shift_q));

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    aligned_d = aligned_q;
    cand_d    = cand_q;
    run_d     = run_q;
    miss_d    = miss_q;
    err_d     = err_q;
    relock_d  = relock_q;

    if (!en) begin
      state_d   = IDLE;
      aligned_d = 1'b0;
      run_d     = '0;
      miss_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          aligned_d = 1'b0;
          state_d   = HUNT;
        end
        HUNT: begin
          aligned_d = 1'b0;
          if (sync_valid && hunt_hit) begin
            cand_d  = hunt_k;
            run_d   = RUN_W'(1);
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (sync_valid) begin
            if (cand_match) begin
              run_d = run_q + RUN_W'(1);
              if (run_q + RUN_W'(1) == RUN_W'(LOCK_COUNT)) begin
                state_d   = LOCKED;
                shift_d   = cand_q;
                aligned_d = 1'b1;
                miss_d    = '0;
                run_d     = '0;
              end
            end else begin
              // The failing byte is dropped, not re-hunted.
              state_d = HUNT;
              run_d   = '0;
            end
          end
        end
        LOCKED: begin
          if (sync_valid) begin
            if (shift_match) begin
              miss_d = '0;
            end else begin
              err_d  = sat_inc_err(err_q);
              miss_d = miss_q + MISS_W'(1);
              if (miss_q + MISS_W'(1) == MISS_W'(LOSS_COUNT)) begin
                state_d   = HUNT;
                aligned_d = 1'b0;
                relock_d  = sat_inc_relock(relock_q);
                miss_d    = '0;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (clear_stats) begin
      err_d    = '0;
      relock_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= 3'd0;
      aligned_q <= 1'b0;
      cand_q    <= 3'd0;
      run_q     <= '0;
      miss_q    <= '0;
      err_q     <= '0;
      relock_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      aligned_q <= aligned_d;
      cand_q    <= cand_d;
      run_q     <= run_d;
      miss_q    <= miss_d;
      err_q     <= err_d;
      relock_q  <= relock_d;
    end
  end

  assign state      = state_q;
  assign shift      = shift_q;
  assign aligned    = aligned_q;
  assign err_cnt    = err_q;
  assign relock_cnt = relock_q;

endmodule
